// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: ALU op codes, bubble constants,
// multiplier FSM states and the ID/EX bundle.
package ex_stage_pkg;

  localparam logic [5:0] EXE_NOP_OP  = 6'd0;
  localparam logic [5:0] EXE_AND_OP  = 6'd1;
  localparam logic [5:0] EXE_OR_OP   = 6'd2;
  localparam logic [5:0] EXE_XOR_OP  = 6'd3;
  localparam logic [5:0] EXE_NOR_OP  = 6'd4;
  localparam logic [5:0] EXE_SLL_OP  = 6'd5;
  localparam logic [5:0] EXE_SRL_OP  = 6'd6;
  localparam logic [5:0] EXE_SRA_OP  = 6'd7;
  localparam logic [5:0] EXE_ADD_OP  = 6'd8;
  localparam logic [5:0] EXE_SUB_OP  = 6'd9;
  localparam logic [5:0] EXE_SLT_OP  = 6'd10;
  localparam logic [5:0] EXE_SLTU_OP = 6'd11;
  localparam logic [5:0] EXE_MUL_OP  = 6'd12;
  localparam logic [5:0] EXE_JAL_OP  = 6'd13;
  localparam logic [5:0] EXE_LB_OP   = 6'd14;
  localparam logic [5:0] EXE_LW_OP   = 6'd15;
  localparam logic [5:0] EXE_SB_OP   = 6'd16;
  localparam logic [5:0] EXE_SW_OP   = 6'd17;

  localparam logic [31:0] ZeroWord   = 32'h0;
  localparam logic [4:0]  NOPRegAddr = 5'h0;

  typedef enum logic [1:0] {MUL_IDLE = 2'd0, MUL_BUSY = 2'd1, MUL_DONE = 2'd2} mul_state_e;

  typedef struct packed {
    logic [5:0]  aluop;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  write_reg;
    logic        we;
    logic [15:0] imm;
    logic [31:0] link;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '{aluop: EXE_NOP_OP, r1: ZeroWord, r2: ZeroWord,
                                    write_reg: NOPRegAddr, we: 1'b0, imm: 16'h0,
                                    link: ZeroWord};

endpackage

// File: rtl/ex_stage_mul.sv
// Iterative shift-add multiplier: one multiplier bit per BUSY cycle,
// then a single DONE cycle presenting the low 32 bits of the product.
module seq_mul32
  import ex_stage_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mul_state_e    state, state_nxt;
  logic [CW-1:0] count;
  logic [31:0]   acc, mcand, mplier;

  always_ff @(posedge clk) begin
    if (rst) state <= MUL_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (start) state_nxt = MUL_BUSY;
      MUL_BUSY: if (count == CW'(MUL_CYCLES - 1)) state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = start ? MUL_BUSY : MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && state != MUL_BUSY) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (state == MUL_BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  assign busy    = (state == MUL_BUSY);
  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, iterative multiplier,
// forwarding/load-hazard info back to decode and the EX/MEM register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  aluop,
  input  logic [31:0] reg_1,
  input  logic [31:0] reg_2,
  input  logic [4:0]  write_reg,
  input  logic        we,
  input  logic [31:0] id_inst,
  input  logic [31:0] link_addr,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_stall_req,
  output logic        exe_we,
  output logic [4:0]  exe_write_reg,
  output logic [31:0] exe_write_data,
  output logic        last_is_load,
  output logic [31:0] exe_load_addr,
  output logic [5:0]  mem_aluop,
  output logic        mem_we,
  output logic [4:0]  mem_write_reg,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store_data
);
  idex_t       ex_q;
  logic        mul_busy, mul_done, mul_start;
  logic [31:0] mul_product;
  logic [31:0] alu_res, store_addr;
  logic        op_known, op_mem, op_store;

  // A busy multiplier owns the stage; flush/stall cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) ex_q <= IDEX_BUBBLE;
    else if (!mul_busy) begin
      if (flush || stall) ex_q <= IDEX_BUBBLE;
      else ex_q <= '{aluop: aluop, r1: reg_1, r2: reg_2, write_reg: write_reg,
                     we: we, imm: id_inst[15:0], link: link_addr};
    end
  end

  assign mul_start = !mul_busy && !flush && !stall && (aluop == EXE_MUL_OP);

  seq_mul32 #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (reg_1),
    .b       (reg_2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_res  = ZeroWord;
    op_known = 1'b1;
    op_mem   = 1'b0;
    case (ex_q.aluop)
      EXE_AND_OP:  alu_res = ex_q.r1 & ex_q.r2;
      EXE_OR_OP:   alu_res = ex_q.r1 | ex_q.r2;
      EXE_XOR_OP:  alu_res = ex_q.r1 ^ ex_q.r2;
      EXE_NOR_OP:  alu_res = ~(ex_q.r1 | ex_q.r2);
      EXE_SLL_OP:  alu_res = ex_q.r2 << ex_q.r1[4:0];
      EXE_SRL_OP:  alu_res = ex_q.r2 >> ex_q.r1[4:0];
      EXE_SRA_OP:  alu_res = $signed(ex_q.r2) >>> ex_q.r1[4:0];
      EXE_ADD_OP:  alu_res = ex_q.r1 + ex_q.r2;
      EXE_SUB_OP:  alu_res = ex_q.r1 - ex_q.r2;
      EXE_SLT_OP:  alu_res = {31'b0, $signed(ex_q.r1) < $signed(ex_q.r2)};
      EXE_SLTU_OP: alu_res = {31'b0, ex_q.r1 < ex_q.r2};
      EXE_MUL_OP:  alu_res = mul_done ? mul_product : ZeroWord;
      EXE_JAL_OP:  alu_res = ex_q.link;
      EXE_LB_OP, EXE_LW_OP, EXE_SB_OP, EXE_SW_OP: op_mem = 1'b1;
      default:     op_known = 1'b0;
    endcase
  end

  assign op_store       = (ex_q.aluop == EXE_SB_OP) || (ex_q.aluop == EXE_SW_OP);
  assign store_addr     = ex_q.r1 + {{16{ex_q.imm[15]}}, ex_q.imm};
  assign ex_stall_req   = mul_busy;
  assign exe_we         = ex_q.we && op_known && !op_mem && !mul_busy;
  assign exe_write_reg  = ex_q.write_reg;
  assign exe_write_data = alu_res;
  assign last_is_load   = (ex_q.aluop == EXE_LB_OP) || (ex_q.aluop == EXE_LW_OP);
  assign exe_load_addr  = ex_q.r1 + ex_q.r2;

  always_ff @(posedge clk) begin
    if (rst || mul_busy) begin
      mem_aluop      <= EXE_NOP_OP;
      mem_we         <= 1'b0;
      mem_write_reg  <= NOPRegAddr;
      mem_write_data <= ZeroWord;
      mem_addr       <= ZeroWord;
      mem_store_data <= ZeroWord;
    end else begin
      mem_aluop      <= ex_q.aluop;
      mem_we         <= ex_q.we && op_known;
      mem_write_reg  <= ex_q.write_reg;
      mem_write_data <= alu_res;
      mem_addr       <= op_store ? store_addr : exe_load_addr;
      mem_store_data <= ex_q.r2;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, multiply and
// stall/flush/reset sequences, then randomized ALU traffic against a model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic [5:0]  aluop = EXE_NOP_OP;
  logic [31:0] reg_1 = '0, reg_2 = '0, id_inst = '0, link_addr = '0;
  logic [4:0]  write_reg = '0;
  logic        we = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        ex_stall_req, exe_we, last_is_load, mem_we;
  logic [4:0]  exe_write_reg, mem_write_reg;
  logic [31:0] exe_write_data, exe_load_addr, mem_write_data, mem_addr, mem_store_data;
  logic [5:0]  mem_aluop;

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .aluop(aluop), .reg_1(reg_1), .reg_2(reg_2),
    .write_reg(write_reg), .we(we), .id_inst(id_inst), .link_addr(link_addr),
    .stall(stall), .flush(flush), .ex_stall_req(ex_stall_req), .exe_we(exe_we),
    .exe_write_reg(exe_write_reg), .exe_write_data(exe_write_data),
    .last_is_load(last_is_load), .exe_load_addr(exe_load_addr),
    .mem_aluop(mem_aluop), .mem_we(mem_we), .mem_write_reg(mem_write_reg),
    .mem_write_data(mem_write_data), .mem_addr(mem_addr), .mem_store_data(mem_store_data)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm, input logic [31:0] link,
                       input logic w, input logic [4:0] wr);
    aluop = op; reg_1 = a; reg_2 = b; id_inst = {16'hA5C3, imm};
    link_addr = link; we = w; write_reg = wr;
  endtask

  // Reference model: results from plain arithmetic on the instruction rules.
  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] link);
    logic [31:0] p2;
    p2 = 32'd1 << a[4:0];
    case (op)
      EXE_AND_OP:  return a & b;
      EXE_OR_OP:   return a | b;
      EXE_XOR_OP:  return a ^ b;
      EXE_NOR_OP:  return ~(a | b);
      EXE_SLL_OP:  return b * p2;
      EXE_SRL_OP:  return b / p2;
      EXE_SRA_OP:  return b[31] ? ~((~b) / p2) : b / p2;
      EXE_ADD_OP:  return a + b;
      EXE_SUB_OP:  return a - b;
      EXE_SLT_OP:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      EXE_SLTU_OP: return (a < b) ? 32'd1 : 32'd0;
      EXE_JAL_OP:  return link;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic bit is_alu(input logic [5:0] op);
    return (op >= EXE_AND_OP && op <= EXE_SLTU_OP) || op == EXE_JAL_OP;
  endfunction

  function automatic bit is_mem(input logic [5:0] op);
    return op == EXE_LB_OP || op == EXE_LW_OP || op == EXE_SB_OP || op == EXE_SW_OP;
  endfunction

  function automatic logic [31:0] ref_addr(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [15:0] imm);
    if (op == EXE_SB_OP || op == EXE_SW_OP) return a + {{16{imm[15]}}, imm};
    return a + b;
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [31:0] r1, r2;
    logic [15:0] imm;
    logic [31:0] link;
    logic        w;
    logic [4:0]  wr;
    logic [31:0] e_data;
    logic        e_we, e_load, e_mwe;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    logic [5:0] rops[16];
    vecs[0]  = '{EXE_ADD_OP,  32'h7FFFFFFF, 32'h1,        16'h0,    32'h0,     1'b1, 5'd5,  32'h80000000, 1'b1, 1'b0, 1'b1, 32'h80000000};
    vecs[1]  = '{EXE_SLT_OP,  32'hFFFFFFFF, 32'h1,        16'h0,    32'h0,     1'b1, 5'd6,  32'h1,        1'b1, 1'b0, 1'b1, 32'h0};
    vecs[2]  = '{EXE_SLTU_OP, 32'hFFFFFFFF, 32'h1,        16'h0,    32'h0,     1'b1, 5'd7,  32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
    vecs[3]  = '{EXE_SRA_OP,  32'h4,        32'h80000000, 16'h0,    32'h0,     1'b1, 5'd8,  32'hF8000000, 1'b1, 1'b0, 1'b1, 32'h80000004};
    vecs[4]  = '{EXE_SW_OP,   32'h100,      32'hDEADBEEF, 16'hFFFC, 32'h0,     1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 32'hFC};
    vecs[5]  = '{EXE_LW_OP,   32'h100,      32'h8,        16'h0,    32'h0,     1'b1, 5'd9,  32'h0,        1'b0, 1'b1, 1'b1, 32'h108};
    vecs[6]  = '{EXE_SUB_OP,  32'h0,        32'h1,        16'h0,    32'h0,     1'b1, 5'd10, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h1};
    vecs[7]  = '{EXE_NOR_OP,  32'hF0F0F0F0, 32'h0000FFFF, 16'h0,    32'h0,     1'b1, 5'd11, 32'h0F0F0000, 1'b1, 1'b0, 1'b1, 32'hF0F1F0EF};
    vecs[8]  = '{EXE_SLL_OP,  32'h1F,       32'h3,        16'h0,    32'h0,     1'b1, 5'd12, 32'h80000000, 1'b1, 1'b0, 1'b1, 32'h22};
    vecs[9]  = '{EXE_SRL_OP,  32'h4,        32'h80000000, 16'h0,    32'h0,     1'b1, 5'd13, 32'h08000000, 1'b1, 1'b0, 1'b1, 32'h80000004};
    vecs[10] = '{EXE_JAL_OP,  32'h0,        32'h0,        16'h0,    32'h400008, 1'b1, 5'd31, 32'h400008,  1'b1, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{6'd63,       32'h5,        32'h6,        16'h0,    32'h0,     1'b1, 5'd14, 32'h0,        1'b0, 1'b0, 1'b0, 32'hB};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst ex_stall_req", ex_stall_req, 0);
    chk("rst exe_we", exe_we, 0);
    chk("rst exe_write_data", exe_write_data, 0);
    chk("rst exe_load_addr", exe_load_addr, 0);
    chk("rst mem_aluop", mem_aluop, 0);
    chk("rst mem_write_data", mem_write_data, 0);
    chk("rst mem_addr", mem_addr, 0);

    // Directed vector table
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].imm, vecs[i].link, vecs[i].w, vecs[i].wr);
      @(negedge clk);
      chk($sformatf("v%0d exe_write_data", i), exe_write_data, vecs[i].e_data);
      chk($sformatf("v%0d exe_we", i), exe_we, vecs[i].e_we);
      chk($sformatf("v%0d exe_write_reg", i), exe_write_reg, vecs[i].wr);
      chk($sformatf("v%0d last_is_load", i), last_is_load, vecs[i].e_load);
      chk($sformatf("v%0d exe_load_addr", i), exe_load_addr, vecs[i].r1 + vecs[i].r2);
      @(negedge clk);
      chk($sformatf("v%0d mem_write_data", i), mem_write_data, vecs[i].e_data);
      chk($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_mwe);
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
      chk($sformatf("v%0d mem_store_data", i), mem_store_data, vecs[i].r2);
      chk($sformatf("v%0d mem_aluop", i), mem_aluop, vecs[i].op);
    end

    // Multiply -3 * 7; junk presented during BUSY must not be latched
    drive(EXE_MUL_OP, 32'hFFFFFFFD, 32'h7, 16'h0, 32'h0, 1'b1, 5'd9);
    @(negedge clk);
    drive(EXE_ADD_OP, 32'h10, 32'h20, 16'h0, 32'h0, 1'b1, 5'd3);
    chk("mul busy exe_we", exe_we, 0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!ex_stall_req) break;
      n++;
      if (c == 20) begin
        chk("mul busy exe_write_reg", exe_write_reg, 9);
        chk("mul busy mem_aluop", mem_aluop, EXE_NOP_OP);
      end
      @(negedge clk);
    end
    chk("mul stall cycles", n, 32);
    chk("mul done exe_write_data", exe_write_data, 32'hFFFFFFEB);
    chk("mul done exe_we", exe_we, 1);
    chk("mul done exe_write_reg", exe_write_reg, 9);
    @(negedge clk);
    chk("mul mem_write_data", mem_write_data, 32'hFFFFFFEB);
    chk("mul mem_we", mem_we, 1);
    chk("mul mem_write_reg", mem_write_reg, 9);
    chk("post-mul ADD accepted", exe_write_data, 32'h30);

    // Reset in the middle of a multiply
    drive(EXE_MUL_OP, 32'h12345, 32'h6789, 16'h0, 32'h0, 1'b1, 5'd4);
    @(negedge clk);
    drive(EXE_NOP_OP, 32'h0, 32'h0, 16'h0, 32'h0, 1'b0, 5'd0);
    repeat (10) @(negedge clk);
    chk("pre-rst busy", ex_stall_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-rst ex_stall_req", ex_stall_req, 0);
    chk("mid-rst exe_write_data", exe_write_data, 0);
    chk("mid-rst exe_write_reg", exe_write_reg, 0);
    chk("mid-rst mem_we", mem_we, 0);
    chk("mid-rst mem_write_data", mem_write_data, 0);
    drive(EXE_ADD_OP, 32'h2, 32'h3, 16'h0, 32'h0, 1'b1, 5'd4);
    @(negedge clk);
    chk("after-rst ADD data", exe_write_data, 5);
    chk("after-rst ADD we", exe_we, 1);
    chk("after-rst stall_req", ex_stall_req, 0);

    // stall, then flush, with an ADD presented
    for (int k = 0; k < 2; k++) begin
      drive(EXE_ADD_OP, 32'h1, 32'h2 + k, 16'h0, 32'h0, 1'b1, 5'd6);
      if (k == 0) stall = 1'b1; else flush = 1'b1;
      @(negedge clk);
      chk($sformatf("hold%0d bubble exe_we", k), exe_we, 0);
      chk($sformatf("hold%0d bubble data", k), exe_write_data, 0);
      stall = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk($sformatf("hold%0d released data", k), exe_write_data, 3 + k);
      chk($sformatf("hold%0d released we", k), exe_we, 1);
    end

    // stall during the DONE cycle: product still reaches MEM, EX bubbles
    drive(EXE_MUL_OP, 32'd6, 32'd7, 16'h0, 32'h0, 1'b1, 5'd2);
    @(negedge clk);
    drive(EXE_ADD_OP, 32'h1, 32'h1, 16'h0, 32'h0, 1'b1, 5'd8);
    for (int c = 0; c < 40 && ex_stall_req; c++) @(negedge clk);
    chk("done-stall product", exe_write_data, 42);
    stall = 1'b1;
    @(negedge clk);
    chk("done-stall mem_write_data", mem_write_data, 42);
    chk("done-stall EX bubble", exe_we, 0);
    stall = 1'b0;
    @(negedge clk);
    chk("done-stall ADD latched", exe_write_data, 2);

    // Randomized ALU/memory traffic vs. the model
    rops = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
             EXE_SRA_OP, EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_JAL_OP,
             EXE_LW_OP, EXE_SW_OP, EXE_NOP_OP, 6'd50};
    for (int t = 0; t < 150; t++) begin
      logic [5:0]  op;
      logic [31:0] a, b, lk;
      logic [15:0] imm;
      logic        w;
      op = rops[$urandom_range(0, 15)];
      a = $urandom; b = $urandom; lk = $urandom; imm = 16'($urandom); w = 1'($urandom);
      drive(op, a, b, imm, lk, w, 5'($urandom));
      @(negedge clk);
      chk("rnd exe_write_data", exe_write_data, ref_alu(op, a, b, lk));
      chk("rnd exe_we", exe_we, w && is_alu(op));
      chk("rnd exe_load_addr", exe_load_addr, a + b);
      chk("rnd last_is_load", last_is_load, op == EXE_LW_OP);
      @(negedge clk);
      chk("rnd mem_write_data", mem_write_data, ref_alu(op, a, b, lk));
      chk("rnd mem_we", mem_we, w && (is_alu(op) || is_mem(op)));
      chk("rnd mem_addr", mem_addr, ref_addr(op, a, b, imm));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
